// File: rtl/sram_port_arbiter_if.sv
// ============================================================================
//  Module      : sram_port_arbiter_if
//  Description : Requester ports and SRAM macro bus bundled for the
//                two-port TCM SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_port_arbiter_if #(
    parameter int AW = 13
);
    logic          p0_req;
    logic [3:0]    p0_wen;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [31:0]   p0_rdata;

    logic          p1_req;
    logic [3:0]    p1_wen;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [31:0]   p1_rdata;

    logic          sram_cs;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    // Arbiter side
    modport slave (
        input  p0_req, p0_wen, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_wen, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output sram_cs, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    // Requesters plus SRAM macro side
    modport master (
        output p0_req, p0_wen, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_wen, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  sram_cs, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one single-port byte-writable 32-bit SRAM between two
//                requesters; fixed priority with starvation guard or RR.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int AW        = 13,
    parameter int ARB_MODE  = 0,
    parameter int MAX_BURST = 4
) (
    input  wire logic     sys_root_clk,
    input  wire logic     sys_root_rstn,
    sram_port_arbiter_if.slave bus
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_owner_q, last_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_port_q, rd_port_d;

    logic       w_gnt0;
    logic       w_gnt1;

    // Grants are forced low while reset is asserted so the SRAM is never
    // strobed and no requester sees a spurious accept.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (sys_root_rstn) begin
            if (bus.p0_req && bus.p1_req) begin
                if (ARB_MODE == 0) begin
                    w_gnt1 = (burst_cnt_q == c_max_burst);
                end else begin
                    w_gnt1 = ~last_owner_q;
                end
                w_gnt0 = ~w_gnt1;
            end else begin
                w_gnt0 = bus.p0_req;
                w_gnt1 = bus.p1_req;
            end
        end
    end

    always_comb begin
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        rd_pend_d    = 1'b0;
        rd_port_d    = rd_port_q;

        if (!bus.p1_req || w_gnt1) begin
            burst_cnt_d = 4'd0;
        end else if (w_gnt0 && (burst_cnt_q < c_max_burst)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end

        if (w_gnt1) begin
            last_owner_d = 1'b1;
        end else if (w_gnt0) begin
            last_owner_d = 1'b0;
        end

        if (w_gnt0 && (bus.p0_wen == 4'd0)) begin
            rd_pend_d = 1'b1;
            rd_port_d = 1'b0;
        end else if (w_gnt1 && (bus.p1_wen == 4'd0)) begin
            rd_pend_d = 1'b1;
            rd_port_d = 1'b1;
        end
    end

    always_ff @(posedge sys_root_clk or negedge sys_root_rstn) begin
        if (!sys_root_rstn) begin
            burst_cnt_q  <= 4'd0;
            last_owner_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
        end
    end

    // SRAM command mux: zeros when idle keep the macro pins quiet.
    always_comb begin
        bus.sram_cs    = w_gnt0 | w_gnt1;
        bus.sram_wen   = 4'd0;
        bus.sram_addr  = '0;
        bus.sram_wdata = 32'd0;
        if (w_gnt0) begin
            bus.sram_wen   = bus.p0_wen;
            bus.sram_addr  = bus.p0_addr;
            bus.sram_wdata = bus.p0_wdata;
        end else if (w_gnt1) begin
            bus.sram_wen   = bus.p1_wen;
            bus.sram_addr  = bus.p1_addr;
            bus.sram_wdata = bus.p1_wdata;
        end
    end

    always_comb begin
        bus.p0_gnt    = w_gnt0;
        bus.p1_gnt    = w_gnt1;
        bus.p0_rvalid = rd_pend_q & ~rd_port_q;
        bus.p1_rvalid = rd_pend_q &  rd_port_q;
        bus.p0_rdata  = (rd_pend_q & ~rd_port_q) ? bus.sram_rdata : 32'd0;
        bus.p1_rdata  = (rd_pend_q &  rd_port_q) ? bus.sram_rdata : 32'd0;
    end

endmodule

`default_nettype wire
